// File: rtl/fp_pipe_ctrl.sv
// Valid/ready control plane for a multi-stage FP datapath: per-stage load enables,
// bubble-collapsing backpressure, synchronous flush and occupancy tracking.
module fp_pipe_ctrl #(
  parameter int stages    = 3,
  parameter int cnt_width = $clog2(stages + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic [stages-1:0]    stage_active,
  output logic [stages-1:0]    stage_valid,
  output logic [cnt_width-1:0] occupancy,
  output logic                 empty
);
  logic [stages-1:0]    r_v;
  logic [cnt_width-1:0] r_occ;
  logic [stages-1:0]    w_rdy;
  logic [stages-1:0]    w_up;
  logic [stages-1:0]    w_v_nxt;
  logic                 w_chain;
  logic                 w_acc;
  logic                 w_emit;

  // Ready ripples from the tail toward the head: a stage can load when it is
  // empty or its own entry is moving on this cycle.
  always_comb begin
    w_rdy   = '0;
    w_chain = out_ready;
    for (int i = stages - 1; i >= 0; i--) begin
      w_chain  = !r_v[i] | w_chain;
      w_rdy[i] = w_chain;
    end
  end

  always_comb begin
    w_up    = '0;
    w_up[0] = in_valid;
    for (int i = 1; i < stages; i++) begin
      w_up[i] = r_v[i-1];
    end
  end

  assign stage_active = w_rdy & w_up & {stages{!flush}};
  assign in_ready     = w_rdy[0] & !flush;
  assign w_v_nxt      = (w_rdy & w_up) | (~w_rdy & r_v);

  // Flush suppresses both handshakes so occupancy never counts a discarded transfer.
  assign w_acc  = in_valid & in_ready;
  assign w_emit = r_v[stages-1] & out_ready & !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v   <= '0;
      r_occ <= '0;
    end else if (flush) begin
      r_v   <= '0;
      r_occ <= '0;
    end else begin
      r_v   <= w_v_nxt;
      r_occ <= r_occ + cnt_width'(w_acc) - cnt_width'(w_emit);
    end
  end

  assign out_valid   = r_v[stages-1];
  assign stage_valid = r_v;
  assign occupancy   = r_occ;
  assign empty       = (r_occ == '0);
endmodule

// File: tb/tb_fp_pipe_ctrl.sv
// Bench for fp_pipe_ctrl: directed scenarios plus randomized traffic, all checked
// against a slot-movement model of the pipeline.
module tb_fp_pipe_ctrl;
  localparam int S  = 3;
  localparam int CW = $clog2(S + 1);
  localparam int PW = 3 + 2 * S + CW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          empty;
  logic [S-1:0]  stage_active;
  logic [S-1:0]  stage_valid;
  logic [CW-1:0] occupancy;
  logic [PW-1:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: m[i] says slot i holds an entry; each cycle entries advance into a
  // vacated slot ahead, the tail leaves when out_ready, the head admits if free.
  bit          m  [S];
  bit          nx [S];
  logic [S-1:0] e_act;
  logic        e_ir;
  logic        e_ov;
  int          e_occ;

  always #5 clk = ~clk;

  fp_pipe_ctrl #(.stages(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .stage_active(stage_active), .stage_valid(stage_valid),
    .occupancy(occupancy), .empty(empty)
  );

  assign obs = {in_ready, out_valid, stage_active, stage_valid, occupancy, empty};

  function automatic void model_clear();
    for (int i = 0; i < S; i++) begin
      m[i]  = 1'b0;
      nx[i] = 1'b0;
    end
  endfunction

  function automatic void model_eval();
    e_occ = 0;
    for (int i = 0; i < S; i++) begin
      nx[i] = 1'b0;
      e_occ += int'(m[i]);
    end
    e_act = '0;
    e_ov  = m[S-1];
    e_ir  = 1'b0;
    if (!flush) begin
      if (m[S-1] && !out_ready) nx[S-1] = 1'b1;
      for (int i = S - 2; i >= 0; i--) begin
        if (m[i]) begin
          if (!nx[i+1]) begin
            nx[i+1]    = 1'b1;
            e_act[i+1] = 1'b1;
          end else begin
            nx[i] = 1'b1;
          end
        end
      end
      e_ir = !nx[0];
      if (in_valid && e_ir) begin
        nx[0]    = 1'b1;
        e_act[0] = 1'b1;
      end
    end
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < S; i++) m[i] = nx[i];
  endfunction

  function automatic logic [PW-1:0] exp_vec();
    logic [S-1:0] sv;
    for (int i = 0; i < S; i++) sv[i] = m[i];
    return {e_ir, e_ov, e_act, sv, CW'(e_occ), (e_occ == 0)};
  endfunction

  task automatic drive(input logic iv, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    #1;
    model_eval();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    model_clear();
    #1;
    n_tests++;
    if (obs !== {1'b1, 1'b0, {S{1'b0}}, {S{1'b0}}, {CW{1'b0}}, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", obs, {1'b1, 1'b0, {S{1'b0}}, {S{1'b0}}, {CW{1'b0}}, 1'b1});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [S-1:0] act_tbl [5];
    logic         ov_tbl  [5];
    act_tbl = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
    ov_tbl  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      drive(c == 0, 1'b1, 1'b0);
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_model c%0d: got %b want %b", c, obs, exp_vec());
      end
      n_tests++;
      if ({stage_active, out_valid} !== {act_tbl[c], ov_tbl[c]}) begin
        n_fail++;
        $display("FAIL single_seq c%0d: got act=%b ov=%b want act=%b ov=%b",
                 c, stage_active, out_valid, act_tbl[c], ov_tbl[c]);
      end
      model_commit();
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int last  = -1;
    int cnt   = 0;
    for (int c = 0; c < 14; c++) begin
      drive(c < 6, 1'b1, 1'b0);
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b_model c%0d: got %b want %b", c, obs, exp_vec());
      end
      if (c < 6) begin
        n_tests++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_in_ready c%0d: got %b want 1", c, in_ready);
        end
      end
      if (c == 5) begin
        n_tests++;
        if (occupancy !== CW'(3)) begin
          n_fail++;
          $display("FAIL b2b_occ: got %0d want 3", occupancy);
        end
      end
      if (out_valid === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
      model_commit();
    end
    n_tests++;
    if (first != 3 || last != 8 || cnt != 6) begin
      n_fail++;
      $display("FAIL b2b_out_window: got first=%0d last=%0d cnt=%0d want 3 8 6", first, last, cnt);
    end
  endtask

  task automatic test_stall();
    int acc = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b0, 1'b0);
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall_model c%0d: got %b want %b", c, obs, exp_vec());
      end
      if (in_ready === 1'b1) acc++;
      model_commit();
    end
    drive(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (acc != 3 || {in_ready, stage_valid, occupancy, stage_active} !== {1'b0, 3'b111, CW'(3), 3'b000}) begin
      n_fail++;
      $display("FAIL stall_full: got acc=%0d ir=%b sv=%b occ=%0d act=%b want 3 0 111 3 000",
               acc, in_ready, stage_valid, occupancy, stage_active);
    end
    model_commit();
  endtask

  task automatic test_full_shift();
    drive(1'b1, 1'b1, 1'b0);
    n_tests++;
    if ({stage_active, in_ready} !== {3'b111, 1'b1} || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL full_shift: got act=%b ir=%b want 111 1", stage_active, in_ready);
    end
    model_commit();
    drive(1'b0, 1'b1, 1'b0);
    n_tests++;
    if (occupancy !== CW'(3)) begin
      n_fail++;
      $display("FAIL full_shift_occ: got %0d want 3", occupancy);
    end
    model_commit();
  endtask

  task automatic test_bubble();
    drive(1'b1, 1'b1, 1'b0);
    model_commit();
    drive(1'b0, 1'b0, 1'b0);
    n_tests++;
    if ({stage_valid, stage_active} !== {3'b101, 3'b010} || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL bubble_fill: got sv=%b act=%b want 101 010", stage_valid, stage_active);
    end
    model_commit();
    drive(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (stage_valid !== 3'b110 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL bubble_next: got sv=%b want 110", stage_valid);
    end
    model_commit();
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, 1'b1);
    n_tests++;
    if ({occupancy, in_ready, stage_active} !== {CW'(2), 1'b0, 3'b000} || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL flush_cycle: got occ=%0d ir=%b act=%b want 2 0 000", occupancy, in_ready, stage_active);
    end
    model_commit();
    drive(1'b0, 1'b0, 1'b0);
    n_tests++;
    if ({stage_valid, occupancy, empty} !== {3'b000, CW'(0), 1'b1}) begin
      n_fail++;
      $display("FAIL flush_after: got sv=%b occ=%0d empty=%b want 000 0 1", stage_valid, occupancy, empty);
    end
    model_commit();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random c%0d: got %b want %b", c, obs, exp_vec());
      end
      model_commit();
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, 1'b0);
      model_commit();
    end
    drive(1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    model_eval();
    n_tests++;
    if (obs !== exp_vec() || {stage_valid, occupancy, empty, out_valid} !== {3'b000, CW'(0), 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got %b want %b", obs, exp_vec());
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    n_tests++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL async_reset_hold: got %b want %b", obs, exp_vec());
    end
    model_commit();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_full_shift();
    test_bubble();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
